// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file debug arbiter.
// Register encodings mirror the core's 16-bit register numbering (AX..DI).
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic [2:0] {
    REG_AX = 3'd0,
    REG_CX = 3'd1,
    REG_DX = 3'd2,
    REG_BX = 3'd3,
    REG_SP = 3'd4,
    REG_BP = 3'd5,
    REG_SI = 3'd6,
    REG_DI = 3'd7
  } reg16_t;

  localparam int STARVE_LIMIT_DEFAULT = 15;

  function automatic int starve_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

  localparam int STARVE_CNT_W = starve_cnt_width(STARVE_LIMIT_DEFAULT);

endpackage

// File: rtl/regfile_debug_arbiter.sv
// Arbitrates the register file between the microcode core and the debug port,
// stealing one stall cycle per 16-bit debug access, with a starvation guard.
module regfile_debug_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_core_is_8_bit,
  input  logic [2:0]  i_core_rd_sel0,
  input  logic [2:0]  i_core_rd_sel1,
  input  logic [2:0]  i_core_wr_sel,
  input  logic [15:0] i_core_wr_val,
  input  logic        i_core_wr_en,
  input  logic        i_core_idle,
  output logic        o_core_stall,
  output logic        o_rf_is_8_bit,
  output logic [2:0]  o_rf_rd_sel0,
  output logic [2:0]  o_rf_rd_sel1,
  output logic [2:0]  o_rf_wr_sel,
  output logic [15:0] o_rf_wr_val,
  output logic        o_rf_wr_en,
  input  logic [15:0] i_rf_rd_val0,
  input  logic        i_dbg_req,
  input  logic        i_dbg_wr,
  input  logic [2:0]  i_dbg_sel,
  input  logic [15:0] i_dbg_wr_val,
  output logic        o_dbg_ack,
  output logic [15:0] o_dbg_rd_val
);

  localparam int                CNT_W   = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       r_state;
  arb_state_t       w_next_state;
  logic             w_grant;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_dbg_wr;
  logic [2:0]       r_dbg_sel;
  logic [15:0]      r_dbg_wr_val;
  logic [15:0]      r_dbg_rd_val;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output is given its pass-through default before the case, so
  // no path through the block leaves a signal unassigned (no latches).
  always_comb begin
    w_next_state  = r_state;
    w_grant       = 1'b0;
    o_core_stall  = 1'b0;
    o_dbg_ack     = 1'b0;
    o_rf_is_8_bit = i_core_is_8_bit;
    o_rf_rd_sel0  = i_core_rd_sel0;
    o_rf_rd_sel1  = i_core_rd_sel1;
    o_rf_wr_sel   = i_core_wr_sel;
    o_rf_wr_val   = i_core_wr_val;
    o_rf_wr_en    = i_core_wr_en;
    unique case (r_state)
      IDLE: begin
        if (i_dbg_req && (i_core_idle || r_starve_cnt == CNT_MAX)) begin
          w_grant      = 1'b1;
          w_next_state = GRANT;
        end
      end
      GRANT: begin
        // Debug owns the write port and read port 0; read port 1 stays with the core.
        o_core_stall  = 1'b1;
        o_rf_is_8_bit = 1'b0;
        o_rf_wr_en    = r_dbg_wr;
        o_rf_wr_sel   = r_dbg_sel;
        o_rf_wr_val   = r_dbg_wr_val;
        o_rf_rd_sel0  = r_dbg_sel;
        w_next_state  = r_dbg_wr ? ACK : READ;
      end
      READ:    w_next_state = ACK;
      ACK: begin
        o_dbg_ack    = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Counts cycles a request has waited in IDLE; frozen while an access is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant || !i_dbg_req)     r_starve_cnt <= '0;
      else if (r_starve_cnt != CNT_MAX) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // NOTE: the latched request payload has no reset; it is loaded on every grant
  // and only consumed in the states that follow a grant.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_dbg_wr     <= i_dbg_wr;
      r_dbg_sel    <= i_dbg_sel;
      r_dbg_wr_val <= i_dbg_wr_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_dbg_rd_val <= '0;
    else if (r_state == READ) r_dbg_rd_val <= i_rf_rd_val0;
  end

  assign o_dbg_rd_val = r_dbg_rd_val;

endmodule
